uart_tx_port: RTL and testbench

Port-mapped UART transmitter that sits directly downstream of the MCU's output bus and consumes its OUTPUT instructions. It decodes io_strb/port_id, queues out_port bytes in a small FIFO and serialises them as 8N1 frames on a TX pin. It returns a status byte for the MCU's in_port mux and raises a one-cycle interrupt request when the queue drains.

---
 rtl/uart_pkg.sv | 10 +
 rtl/sync_fifo.sv | 39 +++
 rtl/uart_tx_port.sv | 110 +++++++++++
 tb/tb_uart_tx_port.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the port-mapped UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam logic [7:0] PORT_DATA_DEF   = 8'h40;
  localparam logic [7:0] PORT_STATUS_DEF = 8'h41;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with wrap-around pointers; pushes when full and pops when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: port-mapped 8N1 UART transmitter with TX FIFO, status byte and drain interrupt
module uart_tx_port
  import uart_pkg::*;
#(
  parameter logic [7:0] PORT_DATA    = PORT_DATA_DEF,
  parameter logic [7:0] PORT_STATUS  = PORT_STATUS_DEF,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_strb,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  output logic [7:0] status,
  output logic       tx,
  output logic       int_req
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, dout;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  logic wr_data, wr_stat, full, empty, avail, pop, tx_n, irq_n, overflow, baud_end;
  assign wr_data  = io_strb & (port_id == PORT_DATA);
  assign wr_stat  = io_strb & (port_id == PORT_STATUS);
  assign avail    = |count;
  assign baud_end = baud == BAUD_MAX;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .pop(pop), .din(out_port),
    .dout(dout), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      int_req  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
      int_req  <= irq_n;
      overflow <= (wr_data & full) ? 1'b1 : (wr_stat & out_port[3]) ? 1'b0 : overflow;
    end
  end
  // A frame ending with data still queued chains straight into the next start bit.
  always_comb begin
    state_n = state;
    baud_n  = (state == IDLE || baud_end) ? '0 : baud + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    irq_n   = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (avail) begin
          pop     = 1'b1;
          shift_n = dout;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: if (baud_end) begin
        state_n = DATA;
        tx_n    = shift[0];
        shift_n = shift >> 1;
        bit_n   = '0;
      end
      DATA: if (baud_end) begin
        if (bit_cnt == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          tx_n    = shift[0];
          shift_n = shift >> 1;
          bit_n   = bit_cnt + 3'd1;
        end
      end
      STOP: if (baud_end) begin
        if (avail) begin
          pop     = 1'b1;
          shift_n = dout;
          tx_n    = 1'b0;
          state_n = START;
        end else begin
          state_n = IDLE;
          irq_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    status           = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_BUSY]  = state != IDLE;
    status[ST_OVF]   = overflow;
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: frame-level reference model with a UART-receiver monitor and byte scoreboard
module tb_uart_tx_port;
  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;
  logic clk = 1'b0, reset = 1'b1, io_strb = 1'b0;
  logic [7:0] port_id = '0, out_port = '0, status;
  logic tx, int_req;
  int tests = 0, fails = 0;
  logic [7:0] mq[$], sbq[$];
  logic [7:0] cur = '0, rx = '0;
  bit m_busy = 0, m_ovf = 0, m_irq = 0, m_rst = 1;
  int cyc = 0, f_start = 0, mp = -1;

  uart_tx_port #(.PORT_DATA(8'h40), .PORT_STATUS(8'h41), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .io_strb(io_strb), .port_id(port_id), .out_port(out_port),
    .status(status), .tx(tx), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: each frame is FRAME cycles long, started by popping the queue head.
  always @(posedge clk) begin : model
    int n;
    cyc++;
    m_rst = reset;
    if (reset) begin
      mq.delete();
      sbq.delete();
      m_busy = 0;
      m_ovf = 0;
      m_irq = 0;
    end else begin
      n = mq.size();
      m_irq = 0;
      if ((!m_busy || cyc - f_start == FRAME) && n > 0) begin
        cur = mq.pop_front();
        sbq.push_back(cur);
        f_start = cyc;
        m_busy = 1;
      end else if (m_busy && cyc - f_start == FRAME) begin
        m_busy = 0;
        m_irq = 1;
      end
      if (io_strb && port_id == 8'h40) begin
        if (n < D) mq.push_back(out_port);
        else m_ovf = 1;
      end else if (io_strb && port_id == 8'h41 && out_port[3]) m_ovf = 0;
    end
  end

  function automatic logic exp_tx();
    int i;
    if (!m_busy) return 1'b1;
    i = (cyc - f_start) / C;
    return i == 0 ? 1'b0 : i <= 8 ? cur[i-1] : 1'b1;
  endfunction

  always @(negedge clk) if (cyc > 0) begin
    chk("status", status, {4'b0, m_ovf, m_busy, mq.size() == D, mq.size() == 0});
    chk("tx", {7'b0, tx}, {7'b0, exp_tx()});
    chk("int_req", {7'b0, int_req}, {7'b0, m_irq});
  end

  // Receiver: samples mid-bit and compares each decoded byte with the scoreboard.
  always @(negedge clk) begin
    if (m_rst) mp = -1;
    else begin
      if (mp < 0 && tx === 1'b0) mp = 0;
      if (mp >= 0) begin
        if (mp % C == C / 2) begin
          if (mp / C == 0) chk("start_bit", {7'b0, tx}, 8'h00);
          else if (mp / C <= 8) rx[mp/C-1] = tx;
          else begin
            chk("stop_bit", {7'b0, tx}, 8'h01);
            tests++;
            if (sbq.size() == 0) begin
              fails++;
              $display("FAIL rx_unexpected cyc=%0d got=%h expected=none", cyc, rx);
            end else begin
              tests--;
              chk("rx_byte", rx, sbq.pop_front());
            end
            mp = -2;
          end
        end
        mp = mp == -2 ? -1 : mp + 1;
      end
    end
  end

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    io_strb = 1'b1;
    port_id = p;
    out_port = d;
    @(negedge clk);
    io_strb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    idle(50);
    wr(8'h40, 8'hA5);
    idle(50);
    wr(8'h40, 8'h55);
    wr(8'h40, 8'h0F);
    wr(8'h40, 8'hF0);
    idle(130);
    for (int i = 1; i <= 6; i++) wr(8'h40, 8'(i * 8'h11));
    idle(5 * FRAME + 20);
    wr(8'h41, 8'h08);
    idle(5);
    wr(8'h42, 8'hFF);
    port_id = 8'h40;
    out_port = 8'hFF;
    idle(10);
    wr(8'h40, 8'h3C);
    wr(8'h40, 8'hC3);
    wr(8'h40, 8'h99);
    idle(4 * C + 2);
    pulse_reset();
    idle(60);
    repeat (400) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: wr(8'h40, 8'($urandom));
        6: wr(8'h41, 8'($urandom));
        7: wr(8'($urandom), 8'($urandom));
        8: idle($urandom_range(1, 40));
        default: if ($urandom_range(0, 20) == 0) pulse_reset(); else idle(1);
      endcase
    end
    idle(D * FRAME + 100);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got=%0d expected=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
